// File: rtl/dbg_log_serializer.sv
// dbg_log_serializer: turns one wide log flit into a header word plus payload words.
// Ports: clk/rst, log_catted_* flit input, out_* word stream, seq_count flits emitted.
module dbg_log_serializer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEST_WIDTH = 16,
  parameter int ID_WIDTH   = 16,
  parameter int CNT_SIZE   = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int ADDR       = 0,
  localparam int LOG_WIDTH =
    DATA_WIDTH + DATA_WIDTH / 8 + 1 + DEST_WIDTH + ID_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LOG_WIDTH-1:0]  log_catted_TDATA,
  input  logic                  log_catted_TVALID,
  output logic                  log_catted_TREADY,
  input  logic                  log_catted_TLAST,
  output logic [DATA_WIDTH-1:0] out_TDATA,
  output logic                  out_TVALID,
  input  logic                  out_TREADY,
  output logic                  out_TLAST,
  output logic [CNT_SIZE-1:0]   seq_count
);

  localparam int NWORDS = (LOG_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int PADW   = NWORDS * DATA_WIDTH;
  localparam int IDXW   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NWORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_WORD
  } state_e;

  state_e                state_q, state_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic [PADW-1:0]       data_q, data_d;
  logic                  last_q, last_d;
  logic [CNT_SIZE-1:0]   seq_q, seq_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;

  logic                  out_fire;
  logic                  in_ready;
  logic                  in_fire;
  logic                  at_last;
  logic [IDXW-1:0]       nxt_idx;
  logic [DATA_WIDTH-1:0] nxt_word;
  logic [DATA_WIDTH-1:0] hdr;

  assign at_last  = (state_q == S_WORD) && (idx_q == IDX_LAST);
  assign out_fire = tvalid_q & out_TREADY;
  // The slot frees up in the same cycle the final word leaves,
  // so back-to-back flits stream without a bubble.
  assign in_ready = (state_q == S_IDLE) | (at_last & out_TREADY);
  assign in_fire  = log_catted_TVALID & in_ready;

  // Index of the word that follows the current one; the out-of-range
  // case after the last word is folded to 0 and never used.
  assign nxt_idx  = (state_q == S_WORD && !at_last) ?
                    idx_q + IDXW'(1) : '0;
  assign nxt_word = data_q[nxt_idx * DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    data_d   = data_q;
    last_d   = last_q;
    seq_d    = seq_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    hdr      = '0;

    case (state_q)
      S_HDR: begin
        if (out_fire) begin
          state_d = S_WORD;
          idx_d   = '0;
          tdata_d = nxt_word;
          tlast_d = (NWORDS == 1);
        end
      end
      S_WORD: begin
        if (out_fire) begin
          if (at_last) begin
            seq_d    = seq_q + CNT_SIZE'(1);
            state_d  = S_IDLE;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            tdata_d  = '0;
          end else begin
            idx_d   = nxt_idx;
            tdata_d = nxt_word;
            tlast_d = (nxt_idx == IDX_LAST);
          end
        end
      end
      default: ;
    endcase

    // Header takes seq_d so a flit accepted on the last-word
    // handshake already carries the incremented sequence number.
    hdr[DATA_WIDTH-1 -: ADDR_WIDTH] = ADDR_WIDTH'(ADDR);
    hdr[CNT_SIZE]                   = log_catted_TLAST;
    hdr[CNT_SIZE-1:0]               = seq_d;

    if (in_fire) begin
      data_d                = '0;
      data_d[LOG_WIDTH-1:0] = log_catted_TDATA;
      last_d                = log_catted_TLAST;
      state_d               = S_HDR;
      idx_d                 = '0;
      tdata_d               = hdr;
      tvalid_d              = 1'b1;
      tlast_d               = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      data_q   <= '0;
      last_q   <= 1'b0;
      seq_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      last_q   <= last_d;
      seq_q    <= seq_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
    end
  end

  assign log_catted_TREADY = in_ready;
  assign out_TDATA         = tdata_q;
  assign out_TVALID        = tvalid_q;
  assign out_TLAST         = tlast_q;
  assign seq_count         = seq_q;

endmodule
